// File: rtl/nn_pkg.sv
// nn_pkg: state encoding and fixed-point helpers shared by mlp_engine and mac_lane.
// NN_ARGMAX_EN adds the S_ARGMAX state.
package nn_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_NEXT,
`ifdef NN_ARGMAX_EN
        S_ARGMAX,
`endif
        S_DONE
    } state_t;

    function automatic int w_base(int l, int n_in, int n_hid);
        return l == 0 ? 0 : n_in + 1 + (l - 1) * (n_hid + 1);
    endfunction

    function automatic int io_base(int l, int n_in, int n_hid);
        return l == 0 ? 0 : n_in + (l - 1) * n_hid;
    endfunction

    // Arithmetic shift floors toward -inf before clamping to the word range
    function automatic logic signed [63:0] sat_relu(logic signed [63:0] v, int frac_w, int data_w, logic relu);
        logic signed [63:0] s, hi, lo;
        s = v >>> frac_w;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        s = s > hi ? hi : s < lo ? lo : s;
        return relu && s < 0 ? 64'sd0 : s;
    endfunction
endpackage

// File: rtl/mlp_engine_if.sv
// mlp_engine_if: start/busy/done handshake, weight RAM, IO RAM and result ports of mlp_engine.
interface mlp_engine_if #(parameter int DATA_W = 16, N_OUT = 10, LANES = 20, ADDR_W = 10);
    logic Start, Busy, Done, X_Wren;
    logic [ADDR_W-1:0] W_Addr, X_Addr;
    logic [LANES-1:0][DATA_W-1:0] W_Q;
    logic [DATA_W-1:0] X_Q, X_D;
    logic [N_OUT-1:0][DATA_W-1:0] Probability;
    logic [$clog2(N_OUT)-1:0] Class;
    modport master (input Start, W_Q, X_Q, output Busy, Done, W_Addr, X_Addr, X_Wren, X_D, Probability, Class);
    modport slave (output Start, W_Q, X_Q, input Busy, Done, W_Addr, X_Addr, X_Wren, X_D, Probability, Class);
endinterface

// File: rtl/mlp_engine_mac_lane.sv
// mac_lane: one neuron accumulator with clear, MAC, bias add and saturating/ReLU readout.
module mac_lane import nn_pkg::*; #(
    parameter int DATA_W = 16, FRAC_W = 8, ACC_W = 42
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    input  logic bias,
    input  logic relu,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y
);
    logic signed [ACC_W-1:0] acc, b;
    logic signed [2*DATA_W-1:0] prod;
    assign prod = w * x;
    assign b = ACC_W'(w) <<< FRAC_W;
    assign y = DATA_W'(sat_relu(64'(acc), FRAC_W, DATA_W, relu));
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) acc <= '0;
        else if (clr) acc <= '0;
        else if (en) acc <= acc + (bias ? b : ACC_W'(prod));
endmodule

// File: rtl/mlp_engine.sv
// mlp_engine: layer-serial MLP sequencer streaming each layer through LANES MAC lanes.
// Define NN_ARGMAX_EN to add the argmax pass that drives Class.
module mlp_engine import nn_pkg::*; #(
    parameter int DATA_W = 16, FRAC_W = 8, N_IN = 784, N_HID = 20, N_HIDDEN = 2,
    parameter int N_OUT = 10, LANES = 20, RD_LAT = 2, ADDR_W = 10
) (
    input logic Clk,
    input logic Reset,
    mlp_engine_if.master bus
);
    localparam int ACC_W = 2 * DATA_W + $clog2(N_IN + 1);
    localparam int TW = $clog2((N_IN > LANES ? N_IN : LANES) + RD_LAT + 2);
    localparam int LW = $clog2(N_HIDDEN + 2);
    state_t state, state_n;
    logic [TW-1:0] tick, n_in, n_out;
    logic [LW-1:0] layer;
    logic [RD_LAT-1:0] vld, bsel;
    logic last, clr, start_ok;
    logic signed [DATA_W-1:0] ys [LANES];
    logic signed [DATA_W-1:0] xd;
    logic [N_OUT-1:0][DATA_W-1:0] prob;
    assign last = layer == LW'(N_HIDDEN);
    assign n_in = layer == '0 ? TW'(N_IN) : TW'(N_HID);
    assign n_out = last ? TW'(N_OUT) : TW'(N_HID);
    assign start_ok = state == S_IDLE && bus.Start;
    assign clr = start_ok || state == S_NEXT;
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = bus.Start ? S_FETCH : S_IDLE;
            S_FETCH:  state_n = tick == n_in ? S_DRAIN : S_FETCH;
            S_DRAIN:  state_n = tick == TW'(RD_LAT - 1) ? S_WRITE : S_DRAIN;
            S_WRITE:  state_n = tick == n_out - TW'(1) ? S_NEXT : S_WRITE;
`ifdef NN_ARGMAX_EN
            S_NEXT:   state_n = last ? S_ARGMAX : S_FETCH;
            S_ARGMAX: state_n = tick == TW'(N_OUT - 1) ? S_DONE : S_ARGMAX;
`else
            S_NEXT:   state_n = last ? S_DONE : S_FETCH;
`endif
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end
    // vld/bsel tag each issued read so its data is consumed RD_LAT cycles later
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            state <= S_IDLE;
            tick <= '0;
            layer <= '0;
            vld <= '0;
            bsel <= '0;
        end else begin
            state <= state_n;
            tick <= state_n != state ? '0 : tick + TW'(1);
            layer <= state == S_IDLE ? '0 : state == S_NEXT && !last ? layer + LW'(1) : layer;
            vld <= RD_LAT'({vld, state == S_FETCH});
            bsel <= RD_LAT'({bsel, state == S_FETCH && tick == n_in});
        end
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mac_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_lane (
            .Clk, .Reset, .clr, .en(vld[RD_LAT-1]), .bias(bsel[RD_LAT-1]), .relu(!last),
            .w(bus.W_Q[g]), .x(bus.X_Q), .y(ys[g]));
    end
    always_comb begin
        xd = '0;
        for (int i = 0; i < LANES; i++) if (tick == TW'(i)) xd = ys[i];
    end
    assign bus.Busy = state != S_IDLE && state != S_DONE;
    assign bus.Done = state == S_DONE;
    assign bus.X_Wren = state == S_WRITE;
    assign bus.X_D = bus.X_Wren ? xd : '0;
    assign bus.W_Addr = state == S_FETCH ? ADDR_W'(w_base(int'(layer), N_IN, N_HID) + int'(tick)) : '0;
    assign bus.X_Addr = state == S_FETCH ? ADDR_W'(io_base(int'(layer), N_IN, N_HID) + int'(tick))
                      : bus.X_Wren ? ADDR_W'(io_base(int'(layer) + 1, N_IN, N_HID) + int'(tick)) : '0;
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) prob <= '0;
        else if (start_ok) prob <= '0;
        else if (bus.X_Wren && last)
            for (int i = 0; i < N_OUT; i++) if (tick == TW'(i)) prob[i] <= xd;
    assign bus.Probability = prob;
`ifdef NN_ARGMAX_EN
    localparam int CW = $clog2(N_OUT);
    logic signed [DATA_W-1:0] cur, best;
    logic [CW-1:0] cls;
    always_comb begin
        cur = '0;
        for (int i = 0; i < N_OUT; i++) if (tick == TW'(i)) cur = prob[i];
    end
    // strict compare keeps the lowest index on ties
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            best <= '0;
            cls <= '0;
        end else if (start_ok) cls <= '0;
        else if (state == S_ARGMAX && (tick == '0 || cur > best)) begin
            best <= cur;
            cls <= CW'(tick);
        end
    assign bus.Class = cls;
`else
    assign bus.Class = '0;
`endif
endmodule
